majo_seq: RTL and testbench
===========================

# majo_seq

Ballot sequencer for the three-input majority voter. It collects one ballot from each of three requesters through per-channel valid/ready handshakes and evaluates the bitwise majority once all ballots are held. It presents the registered result downstream with a valid/ready handshake, plus unanimity and per-voter dissent flags. It sits between the redundant producers and the consumer of the voted value.

## Interface
Parameters:
- VOTE_W, 8, width of each ballot; majority is bitwise across the three ballots.
- TIMEOUT_CYC, 16, cycles allowed between first and last ballot capture (only used with VOTE_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  3  per-voter ballot valid; bit i = voter i.
- in_data  input  3*VOTE_W  ballots; voter i at [i*VOTE_W +: VOTE_W].
- in_ready  output  3  per-voter ready.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  VOTE_W  bitwise majority of the held ballots.
- out_unanimous  output  1  all three held ballots identical.
- out_dissent  output  3  bit i set when ballot i differs from out_data in any bit.
- out_partial  output  1  result was forced by timeout with missing ballots.

## Operation
- States: IDLE (no ballot held), COLLECT (1–2 held), RESULT (output presented).
- Slot flag have[i] per voter. In IDLE/COLLECT: in_ready[i] = ~have[i]. In RESULT: in_ready = 3'b000.
- Capture: on in_valid[i] & in_ready[i], store ballot i and set have[i]. Any subset, including all three, may capture in one cycle.
- IDLE -> COLLECT when 1–2 slots are filled in a cycle. IDLE/COLLECT -> RESULT when all three are held after the edge.
- On entry to RESULT, register out_data, out_unanimous, out_dissent and out_partial from the held ballots. Outputs are stable while out_valid=1 and out_ready=0.
- RESULT -> IDLE on out_ready: clears have[2:0] and out_valid. A new ballot cannot be captured in the same cycle as result acceptance.
- A voter holding valid while its slot is full simply waits. Its data is not sampled until the next round.
- Reset at any point, including mid-collection or mid-RESULT, discards held ballots and returns to IDLE.

## Timing
- Reset values: in_ready=3'b111 (first cycle after reset), out_valid=0, out_data=0, out_unanimous=0, out_dissent=0, out_partial=0, state IDLE, timeout counter 0.
- Latency: last ballot captured at edge N -> out_valid=1 in the cycle following edge N (one register stage).
- Throughput: at best, 1 result per 2 cycles (capture all, then RESULT with out_ready=1).
- in_ready is a function of registered state only (no combinational in_valid -> in_ready path). Likewise out_valid has no combinational dependence on out_ready.

## Configuration
- Macro: VOTE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on the first capture of a round and increments each cycle in COLLECT.
  - When the counter reaches TIMEOUT_CYC-1 and slots are still missing, the FSM enters RESULT next cycle. Missing ballots are treated as all-zero, out_partial=1, and out_dissent bits for missing voters are forced to 1.
  - If the final ballot arrives in the same cycle the timeout fires, the ballot wins and out_partial=0.
- Undefined: no counter. COLLECT waits indefinitely, out_partial is tied to 0 and TIMEOUT_CYC is ignored.

## Structure
- Package majo_pkg: state enum (IDLE, COLLECT, RESULT), NUM_VOTERS=3, timeout counter width constant.
- Sub-module majo_vote: purely combinational VOTE_W-wide bitwise 3-input majority plus unanimity compare. It is instantiated once, fed from the slot registers.

## Test plan
- All three valid in the same cycle with 8'hA5, 8'hA5, 8'h5A -> one cycle later out_valid=1, out_data=8'hA5, out_unanimous=0, out_dissent=3'b100.
- Staggered arrival (voter 0 at cycle 0, voter 2 at 3, voter 1 at 7), all 8'h3C -> in_ready[i] drops after each capture; out_valid at cycle 8 with 8'h3C, out_unanimous=1, out_dissent=0.
- out_ready held low 5 cycles in RESULT while voters re-assert valid -> out_* stable, in_ready=0. After acceptance, IDLE with in_ready=3'b111 and no ballots captured in the acceptance cycle.
- rst asserted in COLLECT with two slots held -> next cycle out_valid=0, in_ready=3'b111. A fresh round of three ballots produces a correct result.
- With VOTE_TIMEOUT_EN, TIMEOUT_CYC=4: voters 0 and 1 send 8'hFF, voter 2 silent -> RESULT after 4 COLLECT cycles with out_data=8'hFF, out_partial=1, out_dissent=3'b100.
- With VOTE_TIMEOUT_EN: voter 2 arrives in the exact timeout cycle -> out_partial=0, normal majority result.

Source files
------------

// File: rtl/majo_pkg.sv
// Shared types and constants for the majo_seq ballot sequencer.
package majo_pkg;

  localparam int unsigned NUM_VOTERS = 3;
  localparam int unsigned TMO_W      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StResult
  } state_e;

endpackage

// File: rtl/majo_vote.sv
// Combinational bitwise 3-input majority with unanimity compare.
module majo_vote #(
  parameter int unsigned VOTE_W = 8
) (
  input  logic [VOTE_W-1:0] a,
  input  logic [VOTE_W-1:0] b,
  input  logic [VOTE_W-1:0] c,
  output logic [VOTE_W-1:0] maj,
  output logic              unanimous
);

  assign maj       = (a & b) | (a & c) | (b & c);
  assign unanimous = (a == b) && (b == c);

endmodule

// File: rtl/majo_seq.sv
// Ballot sequencer: collects three ballots, presents registered majority downstream.
// Optional timeout forcing a partial result is enabled by the VOTE_TIMEOUT_EN macro.
module majo_seq
  import majo_pkg::*;
#(
  parameter int unsigned VOTE_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VOTERS-1:0]        in_valid,
  input  logic [NUM_VOTERS*VOTE_W-1:0] in_data,
  output logic [NUM_VOTERS-1:0]        in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VOTE_W-1:0]            out_data,
  output logic                         out_unanimous,
  output logic [NUM_VOTERS-1:0]        out_dissent,
  output logic                         out_partial
);

  state_e                                state_q;
  logic [NUM_VOTERS-1:0]                 have_q, have_d, capture;
  logic [NUM_VOTERS-1:0][VOTE_W-1:0]     slot_q, slot_d, ballot;
  logic [NUM_VOTERS-1:0]                 dissent_d;
  logic [VOTE_W-1:0]                     maj;
  logic                                  unanimous;
  logic                                  tmo_fire;
  logic                                  go_result;

  assign in_ready = (state_q == StResult) ? '0 : ~have_q;

  // Vote is taken on the post-edge slot contents so the result registers on the capture edge.
  always_comb begin
    capture = in_valid & in_ready;
    have_d  = have_q | capture;
    slot_d  = slot_q;
    ballot  = '0;
    for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
      if (capture[i]) slot_d[i] = in_data[i*VOTE_W +: VOTE_W];
      if (have_d[i])  ballot[i] = slot_d[i];
    end
  end

  majo_vote #(
    .VOTE_W (VOTE_W)
  ) u_vote (
    .a         (ballot[0]),
    .b         (ballot[1]),
    .c         (ballot[2]),
    .maj       (maj),
    .unanimous (unanimous)
  );

  always_comb begin
    dissent_d = '0;
    for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
      dissent_d[i] = ~have_d[i] | (ballot[i] != maj);
    end
  end

`ifdef VOTE_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q;
  // A completing ballot in the firing cycle suppresses the timeout.
  assign tmo_fire = (state_q == StCollect) && (cnt_q == TMO_W'(TIMEOUT_CYC - 1)) &&
                    (have_d != '1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_fire   = 1'b0;
`endif

  assign go_result = (state_q != StResult) && ((&have_d) || tmo_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      have_q        <= '0;
      slot_q        <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_unanimous <= 1'b0;
      out_dissent   <= '0;
      out_partial   <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          have_q <= have_d;
          slot_q <= slot_d;
          if (go_result) begin
            state_q       <= StResult;
            out_valid     <= 1'b1;
            out_data      <= maj;
            out_unanimous <= unanimous;
            out_dissent   <= dissent_d;
            out_partial   <= tmo_fire;
          end else if (|have_d) begin
            state_q <= StCollect;
          end
        end
        StResult: begin
          if (out_ready) begin
            state_q   <= StIdle;
            have_q    <= '0;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef VOTE_TIMEOUT_EN
      if (state_q == StIdle && |capture) begin
        cnt_q <= '0;
      end else if (state_q == StCollect) begin
        cnt_q <= cnt_q + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_majo_seq.sv
// Self-checking bench for majo_seq; scoreboard checks every accepted result.
module tb_majo_seq;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         unan;
    logic [2:0]   dissent;
    logic         partial;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid;
  logic [3*W-1:0] in_data;
  logic [2:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_unanimous;
  logic [2:0]   out_dissent;
  logic         out_partial;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  majo_seq #(
    .VOTE_W      (W),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_unanimous (out_unanimous),
    .out_dissent   (out_dissent),
    .out_partial   (out_partial)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [2:0] held);
    exp_t e;
    logic [W-1:0] x, y, z;
    x = held[0] ? a : '0;
    y = held[1] ? b : '0;
    z = held[2] ? c : '0;
    e.data    = (x & y) | (x & z) | (y & z);
    e.unan    = (x == y) && (y == z);
    e.dissent = {~held[2] | (z != e.data), ~held[1] | (y != e.data), ~held[0] | (x != e.data)};
    e.partial = (held != 3'b111);
    return e;
  endfunction

  // Scoreboard: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h with no expected result", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_data, out_unanimous, out_dissent, out_partial} !== e) begin
          errors++;
          $display("FAIL sb_result got data=%h unan=%b dis=%b part=%b want data=%h unan=%b dis=%b part=%b",
                   out_data, out_unanimous, out_dissent, out_partial,
                   e.data, e.unan, e.dissent, e.partial);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 3'b111 || out_valid !== 1'b0 || out_data !== '0 ||
        out_unanimous !== 1'b0 || out_dissent !== 3'b000 || out_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b val=%b data=%h unan=%b dis=%b part=%b want 111 0 00 0 000 0",
               in_ready, out_valid, out_data, out_unanimous, out_dissent, out_partial);
    end
  endtask

  task automatic test_same_cycle();
    in_data  = {8'h5A, 8'hA5, 8'hA5};
    in_valid = 3'b111;
    sb.push_back(model(8'hA5, 8'hA5, 8'h5A, 3'b111));
    step();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_unanimous !== 1'b0 ||
        out_dissent !== 3'b100 || in_ready !== 3'b000) begin
      errors++;
      $display("FAIL same_cycle got val=%b data=%h unan=%b dis=%b rdy=%b want 1 a5 0 100 000",
               out_valid, out_data, out_unanimous, out_dissent, in_ready);
    end
    accept();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 3'b111) begin
      errors++;
      $display("FAIL same_cycle_accept got val=%b rdy=%b want 0 111", out_valid, in_ready);
    end
  endtask

  task automatic test_staggered();
    logic [2:0] want_rdy;
    in_data = {3{8'h3C}};
    sb.push_back(model(8'h3C, 8'h3C, 8'h3C, 3'b111));
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0) ? 3'b001 : (c == 3) ? 3'b100 : (c == 7) ? 3'b010 : 3'b000;
      step();
      in_valid = '0;
      want_rdy = (c < 3) ? 3'b110 : (c < 7) ? 3'b010 : 3'b000;
      checks++;
      if (in_ready !== want_rdy || out_valid !== (c == 7)) begin
        errors++;
        $display("FAIL staggered_c%0d got rdy=%b val=%b want %b %b",
                 c, in_ready, out_valid, want_rdy, (c == 7));
      end
    end
    checks++;
    if (out_data !== 8'h3C || out_unanimous !== 1'b1 || out_dissent !== 3'b000) begin
      errors++;
      $display("FAIL staggered_out got data=%h unan=%b dis=%b want 3c 1 000",
               out_data, out_unanimous, out_dissent);
    end
    accept();
  endtask

  task automatic test_backpressure();
    in_data  = {8'h33, 8'h22, 8'h11};
    in_valid = 3'b111;
    sb.push_back(model(8'h11, 8'h22, 8'h33, 3'b111));
    step();
    in_data = {8'hCC, 8'hBB, 8'hAA};
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_dissent !== 3'b011 ||
          out_unanimous !== 1'b0 || in_ready !== 3'b000) begin
        errors++;
        $display("FAIL backpressure_c%0d got val=%b data=%h dis=%b unan=%b rdy=%b want 1 33 011 0 000",
                 c, out_valid, out_data, out_dissent, out_unanimous, in_ready);
      end
    end
    // Distinct data on the acceptance cycle exposes any illegal capture.
    in_data = {3{8'hDD}};
    accept();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 3'b111) begin
      errors++;
      $display("FAIL backpressure_accept got val=%b rdy=%b want 0 111", out_valid, in_ready);
    end
    in_data = {8'hCC, 8'hBB, 8'hAA};
    sb.push_back(model(8'hAA, 8'hBB, 8'hCC, 3'b111));
    step();
    in_valid = '0;
    accept();
  endtask

  task automatic test_reset_mid();
    in_data  = {8'h00, 8'h77, 8'h66};
    in_valid = 3'b011;
    step();
    in_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid got val=%b rdy=%b want 0 111", out_valid, in_ready);
    end
    in_data  = {8'hFF, 8'hF0, 8'h0F};
    in_valid = 3'b111;
    sb.push_back(model(8'h0F, 8'hF0, 8'hFF, 3'b111));
    step();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_dissent !== 3'b011) begin
      errors++;
      $display("FAIL reset_mid_round got val=%b data=%h dis=%b want 1 ff 011",
               out_valid, out_data, out_dissent);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, c;
    out_ready = 1'b1;
    in_valid  = 3'b111;
    for (int r = 0; r < 6; r++) begin
      a = W'($urandom);
      b = (r % 2 == 0) ? a : W'($urandom);
      c = W'($urandom);
      in_data = {c, b, a};
      sb.push_back(model(a, b, c, 3'b111));
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_r%0d got val=%b want 1", r, out_valid);
      end
      step();
    end
    in_valid  = '0;
    out_ready = 1'b0;
  endtask

`ifdef VOTE_TIMEOUT_EN
  task automatic test_timeout();
    in_data  = {8'h55, 8'hFF, 8'hFF};
    in_valid = 3'b011;
    sb.push_back(model(8'hFF, 8'hFF, 8'h55, 3'b011));
    step();
    in_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (out_valid !== (c == 4)) begin
        errors++;
        $display("FAIL timeout_c%0d got val=%b want %b", c, out_valid, (c == 4));
      end
    end
    checks++;
    if (out_data !== 8'hFF || out_partial !== 1'b1 || out_dissent !== 3'b100) begin
      errors++;
      $display("FAIL timeout_out got data=%h part=%b dis=%b want ff 1 100",
               out_data, out_partial, out_dissent);
    end
    accept();
  endtask

  task automatic test_timeout_race();
    in_data  = {8'h01, 8'h81, 8'h81};
    in_valid = 3'b011;
    sb.push_back(model(8'h81, 8'h81, 8'h01, 3'b111));
    step();
    in_valid = '0;
    step(); step(); step();
    in_valid = 3'b100;
    step();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_partial !== 1'b0 || out_data !== 8'h81 ||
        out_dissent !== 3'b100) begin
      errors++;
      $display("FAIL timeout_race got val=%b part=%b data=%h dis=%b want 1 0 81 100",
               out_valid, out_partial, out_data, out_dissent);
    end
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_same_cycle();
    test_staggered();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef VOTE_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
